// File: rtl/axi_write_burst.sv
// Stream-to-AXI4 write master: buffers stream beats in a FWFT FIFO and writes
// fixed-length INCR bursts that walk a wrapping address window.
module axi_write_burst #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    BURST_LEN    = 16,
    parameter bit                    FLIP_BYTE    = 1'b0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    ADDR_STEP    = 4096,
    parameter int                    REGION_BYTES = 65536
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [DATA_WIDTH-1:0]                s_tdata,
    input  logic                                 s_tvalid,
    output logic                                 s_tready,
    output logic                                 o_wr_done,
    output logic                                 o_wr_err,
    output logic [$clog2(2*BURST_LEN):0]         o_fifo_cnt,
    output logic                                 m_axi_awid,
    output logic [ADDR_WIDTH-1:0]                m_axi_awaddr,
    output logic [7:0]                           m_axi_awlen,
    output logic [2:0]                           m_axi_awsize,
    output logic [1:0]                           m_axi_awburst,
    output logic                                 m_axi_awlock,
    output logic [3:0]                           m_axi_awcache,
    output logic [2:0]                           m_axi_awprot,
    output logic [3:0]                           m_axi_awqos,
    output logic                                 m_axi_awvalid,
    input  logic                                 m_axi_awready,
    output logic [DATA_WIDTH-1:0]                m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]              m_axi_wstrb,
    output logic                                 m_axi_wlast,
    output logic                                 m_axi_wvalid,
    input  logic                                 m_axi_wready,
    input  logic                                 m_axi_bid,
    input  logic [1:0]                           m_axi_bresp,
    input  logic                                 m_axi_bvalid,
    output logic                                 m_axi_bready
);
    localparam int                    DEPTH     = 2 * BURST_LEN;
    localparam int                    PTR_W     = $clog2(DEPTH);
    localparam int                    CNT_W     = $clog2(2 * BURST_LEN) + 1;
    localparam int                    NBYTES    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [ADDR_WIDTH-1:0] WRAP_AT   = BASE_ADDR + ADDR_WIDTH'(REGION_BYTES) - STEP;
    localparam logic [7:0]            LAST_BEAT = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rdy;
    logic [7:0]            r_beat;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    generate
        if (FLIP_BYTE) begin : g_flip
            for (genvar i = 0; i < NBYTES; i++) begin : g_byte
                assign w_din[8*i +: 8] = s_tdata[8*(NBYTES-1-i) +: 8];
            end
        end else begin : g_pass
            assign w_din = s_tdata;
        end
    endgenerate

    // r_rdy keeps the stream stalled until the first clock after reset release.
    assign w_full     = (r_cnt == CNT_W'(DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign s_tready   = r_rdy && !w_full;
    assign w_push     = s_tvalid && s_tready;
    assign w_pop      = m_axi_wvalid && m_axi_wready;
    assign w_last     = (r_beat == LAST_BEAT);
    assign o_fifo_cnt = r_cnt;
    assign w_unused   = m_axi_bid;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_rdy  <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_cnt >= CNT_W'(BURST_LEN)) w_next = S_AW;
            S_AW:    if (m_axi_awready) w_next = S_W;
            S_W:     if (w_pop && w_last) w_next = S_B;
            S_B:     if (m_axi_bvalid) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Error bursts still advance the address so the read side stays in step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat  <= '0;
            r_bresp <= '0;
            r_addr  <= BASE_ADDR;
        end else begin
            if (w_pop) begin
                r_beat <= w_last ? 8'd0 : r_beat + 8'd1;
            end
            if (r_state == S_B && m_axi_bvalid) begin
                r_bresp <= m_axi_bresp;
            end
            if (r_state == S_DONE) begin
                r_addr <= (r_addr >= WRAP_AT) ? BASE_ADDR : r_addr + STEP;
            end
        end
    end

    always_comb begin
        m_axi_awvalid = (r_state == S_AW);
        m_axi_wvalid  = (r_state == S_W) && !w_empty;
        m_axi_wlast   = (r_state == S_W) && w_last;
        m_axi_bready  = (r_state == S_B);
        o_wr_done     = (r_state == S_DONE);
        o_wr_err      = (r_state == S_DONE) && (r_bresp != 2'b00);
    end

    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = 3'($clog2(NBYTES));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd3;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_wdata   = r_mem[r_rptr];
    assign m_axi_wstrb   = '1;

endmodule

// File: tb/tb_axi_write_burst.sv
// Scoreboard bench for axi_write_burst: a reactive AXI slave, a stream driver
// and a negedge monitor that checks AW/W/B traffic against queued expectations.
module tb_axi_write_burst;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int BL    = 16;
    localparam int STEP  = 4096;
    localparam int NWRAP = 65536 / 4096;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DW-1:0]    s_tdata = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic             o_wr_done, o_wr_err;
    logic [5:0]       o_fifo_cnt;
    logic             m_axi_awid;
    logic [AW-1:0]    m_axi_awaddr;
    logic [7:0]       m_axi_awlen;
    logic [2:0]       m_axi_awsize;
    logic [1:0]       m_axi_awburst;
    logic             m_axi_awlock;
    logic [3:0]       m_axi_awcache;
    logic [2:0]       m_axi_awprot;
    logic [3:0]       m_axi_awqos;
    logic             m_axi_awvalid;
    logic             m_axi_awready = 1'b0;
    logic [DW-1:0]    m_axi_wdata;
    logic [DW/8-1:0]  m_axi_wstrb;
    logic             m_axi_wlast, m_axi_wvalid;
    logic             m_axi_wready = 1'b0;
    logic             m_axi_bid = 1'b0;
    logic [1:0]       m_axi_bresp = 2'b00;
    logic             m_axi_bvalid = 1'b0;
    logic             m_axi_bready;

    int total = 0;
    int bad = 0;

    int       awDelay = 0;
    bit       wToggle = 0;
    bit       bHold = 0;
    logic [1:0] bRespVal = 2'b00;
    int       awWait = 0;

    logic [DW-1:0] nextVal = '0;

    logic [DW-1:0] dataQ[$];
    logic [AW-1:0] addrQ[$];
    bit            errQ[$];
    int            pushCnt = 0;
    int            burstIdx = 0;
    int            beatIdx = 0;
    int            popCnt = 0;
    int            doneCnt = 0;
    bit            prevAwv = 0;
    logic [AW-1:0] prevAwAddr = '0;
    bit            prevWStall = 0;
    logic [DW-1:0] prevWData = '0;
    logic          prevWLast = 1'b0;
    logic          prevDone = 1'b0;

    axi_write_burst #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FLIP_BYTE(1'b0),
        .BASE_ADDR('0), .ADDR_STEP(STEP), .REGION_BYTES(65536)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .o_wr_done(o_wr_done), .o_wr_err(o_wr_err), .o_fifo_cnt(o_fifo_cnt),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reactive slave: delayed awready, optional toggling wready, held-off bvalid.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            awWait        = 0;
        end else begin
            if (m_axi_awvalid) begin
                m_axi_awready = (awWait >= awDelay);
                awWait++;
            end else begin
                m_axi_awready = 1'b0;
                awWait        = 0;
            end
            m_axi_wready = wToggle ? !m_axi_wready : 1'b1;
            m_axi_bvalid = m_axi_bready && !bHold;
            m_axi_bresp  = bRespVal;
        end
    end

    // Handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            dataQ.delete();
            addrQ.delete();
            errQ.delete();
            pushCnt    = 0;
            burstIdx   = 0;
            beatIdx    = 0;
            prevAwv    = 0;
            prevWStall = 0;
            prevDone   = 1'b0;
        end else begin
            if (s_tvalid && s_tready) begin
                dataQ.push_back(s_tdata);
                pushCnt++;
                if (pushCnt % BL == 0) begin
                    addrQ.push_back(AW'((burstIdx % NWRAP) * STEP));
                    burstIdx++;
                end
            end
            if (m_axi_awvalid) begin
                checkOutput("awWOverlap", m_axi_wvalid, 0);
                if (prevAwv) checkOutput("awaddrStable", m_axi_awaddr, prevAwAddr);
                if (m_axi_awready) begin
                    if (addrQ.size() == 0) checkOutput("awUnexpected", m_axi_awvalid, 0);
                    else checkOutput("awaddr", m_axi_awaddr, addrQ.pop_front());
                    checkOutput("awlen", m_axi_awlen, BL - 1);
                    checkOutput("awsize", m_axi_awsize, 3);
                    checkOutput("awburst", m_axi_awburst, 1);
                    prevAwv = 0;
                end else begin
                    prevAwv    = 1;
                    prevAwAddr = m_axi_awaddr;
                end
            end else begin
                prevAwv = 0;
            end
            if (m_axi_wvalid) begin
                if (prevWStall) begin
                    checkOutput("wdataStable", m_axi_wdata, prevWData);
                    checkOutput("wlastStable", m_axi_wlast, prevWLast);
                end
                if (m_axi_wready) begin
                    if (dataQ.size() == 0) checkOutput("wUnexpected", m_axi_wvalid, 0);
                    else checkOutput("wdata", m_axi_wdata, dataQ.pop_front());
                    checkOutput("wlast", m_axi_wlast, beatIdx == BL - 1);
                    beatIdx    = (beatIdx == BL - 1) ? 0 : beatIdx + 1;
                    popCnt++;
                    prevWStall = 0;
                end else begin
                    prevWStall = 1;
                    prevWData  = m_axi_wdata;
                    prevWLast  = m_axi_wlast;
                end
            end else begin
                prevWStall = 0;
            end
            if (m_axi_bvalid && m_axi_bready) errQ.push_back(m_axi_bresp != 2'b00);
            if (o_wr_done) begin
                checkOutput("donePulseWidth", prevDone, 0);
                if (errQ.size() == 0) checkOutput("doneUnexpected", o_wr_done, 0);
                else checkOutput("wrErr", o_wr_err, errQ.pop_front());
                doneCnt++;
            end else if (o_wr_err) begin
                checkOutput("errWithoutDone", o_wr_err, 0);
            end
            prevDone = o_wr_done;
        end
    end

    task automatic applyStimulus(input int n);
        int  sent = 0;
        int  cyc = 0;
        bit  hs;
        @(posedge clk);
        #1;
        while (sent < n && cyc < 5000) begin
            s_tvalid = 1'b1;
            s_tdata  = nextVal;
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                sent++;
                nextVal++;
            end
            cyc++;
        end
        s_tvalid = 1'b0;
        checkOutput("streamAccepted", sent, n);
    endtask

    task automatic waitDone(input int target);
        int cyc = 0;
        while (doneCnt < target && cyc < 3000) begin
            @(posedge clk);
            #3;
            cyc++;
        end
        checkOutput("doneReached", doneCnt >= target, 1);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #3;
        checkOutput("dataQEmpty", dataQ.size(), 0);
        checkOutput("addrQEmpty", addrQ.size(), 0);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("treadyAfterRst", s_tready, 1);
    endtask

    task automatic resetDut();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        nextVal  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstFifoCnt", o_fifo_cnt, 0);
        checkOutput("rstTready", s_tready, 0);
        releaseReset();
    endtask

    initial begin
        int target;
        int popStart;
        int cyc;

        $display("[TB] reset values");
        #23;
        checkOutput("rstAwvalid", m_axi_awvalid, 0);
        checkOutput("rstWvalid", m_axi_wvalid, 0);
        checkOutput("rstWlast", m_axi_wlast, 0);
        checkOutput("rstBready", m_axi_bready, 0);
        checkOutput("rstDone", o_wr_done, 0);
        checkOutput("rstErr", o_wr_err, 0);
        checkOutput("rstFifoCnt", o_fifo_cnt, 0);
        checkOutput("rstTready", s_tready, 0);
        releaseReset();

        $display("[TB] single burst");
        target = doneCnt + 1;
        applyStimulus(16);
        waitDone(target);
        settle();

        $display("[TB] error response then advanced address");
        bRespVal = 2'b10;
        target = doneCnt + 1;
        applyStimulus(16);
        waitDone(target);
        bRespVal = 2'b00;
        target = doneCnt + 1;
        applyStimulus(16);
        waitDone(target);
        settle();

        $display("[TB] backpressure");
        awDelay  = 5;
        wToggle  = 1;
        popStart = popCnt;
        target   = doneCnt + 1;
        applyStimulus(16);
        waitDone(target);
        settle();
        checkOutput("bpPops", popCnt - popStart, 16);
        awDelay = 0;
        wToggle = 0;

        $display("[TB] fifo full");
        bHold  = 1;
        target = doneCnt + 3;
        applyStimulus(48);
        cyc = 0;
        while (o_fifo_cnt != 6'd32 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("fullCnt", o_fifo_cnt, 32);
        checkOutput("fullTready", s_tready, 0);
        repeat (5) @(negedge clk);
        checkOutput("fullTreadyHeld", s_tready, 0);
        checkOutput("fullCntHeld", o_fifo_cnt, 32);
        bHold = 0;
        waitDone(target);
        settle();

        $display("[TB] address sequence with wrap");
        resetDut();
        target = doneCnt + 17;
        applyStimulus(17 * BL);
        waitDone(target);
        settle();

        $display("[TB] reset mid-burst");
        resetDut();
        popStart = popCnt;
        applyStimulus(16);
        cyc = 0;
        while (popCnt - popStart < 7 && cyc < 200) begin
            @(posedge clk);
            #3;
            cyc++;
        end
        checkOutput("abortReached", (popCnt - popStart) >= 7, 1);
        target   = doneCnt;
        rst_n    = 1'b0;
        nextVal  = '0;
        #1;
        checkOutput("abortAwvalid", m_axi_awvalid, 0);
        checkOutput("abortWvalid", m_axi_wvalid, 0);
        checkOutput("abortBready", m_axi_bready, 0);
        checkOutput("abortFifoCnt", o_fifo_cnt, 0);
        checkOutput("abortDone", o_wr_done, 0);
        repeat (2) @(posedge clk);
        releaseReset();
        applyStimulus(16);
        waitDone(target + 1);
        settle();
        repeat (20) @(posedge clk);
        #3;
        checkOutput("abortDoneCount", doneCnt - target, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
